// File: rtl/frame_transmitter.sv
// frame_transmitter: emits one frame of FRAME_LEN incrementing 32-bit words per
// i_start pulse over a valid/ready stream. The reference sequence carries on
// across frames and only i_rst returns it to 0, so a checker-side generator
// started by the same pulse sees identical data.
// Optional build macro FRAME_TX_ERR_INJECT_EN adds i_err_inject, which corrupts
// the word at ERR_IDX (bit 0 flipped) in the frame whose start it accompanies.
module frame_transmitter #(
  parameter int FRAME_LEN = 64,
  parameter int ERR_IDX   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_ready,
`ifdef FRAME_TX_ERR_INJECT_EN
  input  logic        i_err_inject,
`endif
  output logic        o_data_valid,
  output logic [31:0] o_data,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
);

  localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 1);
  localparam logic [6:0] ERR_POS  = 7'(ERR_IDX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] seq_r, seq_s;
  logic [6:0]  idx_r, idx_s;
  logic        valid_r, valid_s;
  logic [31:0] data_r, data_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [15:0] cnt_r, cnt_s;
  logic [31:0] seq_inc_s;
  logic [6:0]  idx_inc_s;
  logic        arm_start_s;
  logic        arm_cur_s;

  // Word put on the bus: the sequence value, optionally with bit 0 flipped.
  function automatic logic [31:0] word_value(input logic [31:0] seq, input logic flip);
    return seq ^ {31'd0, flip};
  endfunction

  assign seq_inc_s = seq_r + 32'd1;
  assign idx_inc_s = idx_r + 7'd1;

`ifdef FRAME_TX_ERR_INJECT_EN
  logic arm_r;
  logic arm_next_s;

  // Capture the injection request with an accepted start; drop it once the frame is done.
  always_comb begin
    arm_next_s = arm_r;
    if ((state_r == ST_IDLE) && i_start) begin
      arm_next_s = i_err_inject;
    end else if (state_r == ST_DONE) begin
      arm_next_s = 1'b0;
    end else begin
      arm_next_s = arm_r;
    end
  end

  // Injection arming register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      arm_r <= 1'b0;
    end else begin
      arm_r <= arm_next_s;
    end
  end

  assign arm_start_s = i_err_inject;
  assign arm_cur_s   = arm_r;
`else
  assign arm_start_s = 1'b0;
  assign arm_cur_s   = 1'b0;
`endif

  // Next-state and next-output logic; every registered value holds unless changed below.
  always_comb begin
    state_s = state_r;
    seq_s   = seq_r;
    idx_s   = idx_r;
    valid_s = valid_r;
    data_s  = data_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        busy_s  = 1'b0;
        valid_s = 1'b0;
        if (i_start) begin
          // First word of the frame is the current sequence value.
          state_s = ST_SEND;
          valid_s = 1'b1;
          busy_s  = 1'b1;
          data_s  = word_value(seq_r, arm_start_s && (ERR_POS == 7'd0));
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        busy_s = 1'b1;
        if (valid_r && i_ready) begin
          seq_s = seq_inc_s;
          if (idx_r == LAST_IDX) begin
            state_s = ST_DONE;
            valid_s = 1'b0;
            done_s  = 1'b1;
            cnt_s   = cnt_r + 16'd1;
            idx_s   = 7'd0;
          end else begin
            // Valid stays high across the whole frame; only data advances.
            idx_s  = idx_inc_s;
            data_s = word_value(seq_inc_s, arm_cur_s && (idx_inc_s == ERR_POS));
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        // Starts seen here are dropped; a new frame needs a start while idle.
        state_s = ST_IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        idx_s   = 7'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      seq_r   <= 32'd0;
      idx_r   <= 7'd0;
      valid_r <= 1'b0;
      data_r  <= 32'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      seq_r   <= seq_s;
      idx_r   <= idx_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      cnt_r   <= cnt_s;
    end
  end

  assign o_data_valid = valid_r;
  assign o_data       = data_r;
  assign o_busy       = busy_r;
  assign o_frame_done = done_r;
  assign o_frame_cnt  = cnt_r;

endmodule

// File: tb/tb_frame_transmitter.sv
// Bench for frame_transmitter: a FRAME_LEN=4 instance checked through a word
// scoreboard plus directed checks, and a FRAME_LEN=1 instance for the
// single-word frame case.
module tb_frame_transmitter;
  localparam int FL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ready, start1;
  logic        valid, busy, done, valid1, busy1, done1;
  logic [31:0] data, data1;
  logic [15:0] cnt, cnt1;
`ifdef FRAME_TX_ERR_INJECT_EN
  logic        err_inject;
`endif

  int          total = 0;
  int          bad = 0;
  int          vc;
  logic [31:0] exp_q[$];
  logic [31:0] exp_seq;

  frame_transmitter #(.FRAME_LEN(FL), .ERR_IDX(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(ready),
`ifdef FRAME_TX_ERR_INJECT_EN
    .i_err_inject(err_inject),
`endif
    .o_data_valid(valid), .o_data(data), .o_busy(busy),
    .o_frame_done(done), .o_frame_cnt(cnt)
  );

  frame_transmitter #(.FRAME_LEN(1), .ERR_IDX(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_ready(1'b1),
`ifdef FRAME_TX_ERR_INJECT_EN
    .i_err_inject(1'b0),
`endif
    .o_data_valid(valid1), .o_data(data1), .o_busy(busy1),
    .o_frame_done(done1), .o_frame_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the word handed over at the coming edge, then land on the next negedge.
  task automatic step();
    logic [31:0] w;
    if (valid === 1'b1 && ready === 1'b1) begin
      chk("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("word", data, w);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_frame(input logic inj);
    for (int i = 0; i < FL; i++) begin
      exp_q.push_back((exp_seq + 32'(i)) ^ {31'd0, (inj && i == 1)});
    end
    exp_seq = exp_seq + 32'(FL);
    start = 1'b1;
`ifdef FRAME_TX_ERR_INJECT_EN
    err_inject = inj;
`endif
    step();
    start = 1'b0;
`ifdef FRAME_TX_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    chk("start_valid", 32'(valid), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int vcnt);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) break;
      if (valid === 1'b1) vcnt++;
      step();
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1; start1 = 1'b0;
`ifdef FRAME_TX_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    exp_seq = 32'd0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);

    // Frame 0: words 0..3, exactly four valid cycles.
    start_frame(1'b0);
    wait_done(vc);
    chk("f0_valid_cycles", 32'(vc), 32'd4);
    chk("f0_cnt", 32'(cnt), 32'd1);
    chk("f0_done_valid", 32'(valid), 32'd0);
    chk("f0_done_busy", 32'(busy), 32'd1);
    step();
    chk("f0_idle_busy", 32'(busy), 32'd0);
    chk("f0_idle_done", 32'(done), 32'd0);

    // Frame 1 continues the sequence: 4..7.
    start_frame(1'b0);
    wait_done(vc);
    chk("f1_valid_cycles", 32'(vc), 32'd4);
    chk("f1_cnt", 32'(cnt), 32'd2);
    step();
    chk("f1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure after reset: word 1 held through three stalled cycles.
    rst = 1'b1; step(); rst = 1'b0;
    exp_q.delete(); exp_seq = 32'd0;
    start_frame(1'b0);
    step();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_hold", data, 32'd1);
      step();
    end
    ready = 1'b1;
    wait_done(vc);
    chk("stall_valid_cycles", 32'(vc + 4), 32'd7);
    chk("stall_cnt", 32'(cnt), 32'd1);
    step();

    // Start held high through SEND, DONE and the DONE->IDLE edge: one frame only.
    start_frame(1'b0);
    start = 1'b1;
    wait_done(vc);
    step();
    start = 1'b0;
    chk("restart_ignored_valid", 32'(valid), 32'd0);
    chk("restart_ignored_busy", 32'(busy), 32'd0);
    chk("restart_ignored_cnt", 32'(cnt), 32'd2);
    step();
    chk("restart_ignored_valid2", 32'(valid), 32'd0);
    chk("restart_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame after two words; the frame is abandoned.
    start_frame(1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete(); exp_seq = 32'd0;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_data", data, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_wins_valid", 32'(valid), 32'd0);
    step();
    chk("rst_wins_busy", 32'(busy), 32'd0);
    start_frame(1'b0);
    wait_done(vc);
    chk("postrst_valid_cycles", 32'(vc), 32'd4);
    chk("postrst_cnt", 32'(cnt), 32'd1);
    step();
    chk("postrst_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef FRAME_TX_ERR_INJECT_EN
    // Injected frame flips word 1 only; the following frame is clean.
    start_frame(1'b1);
    wait_done(vc);
    step();
    start_frame(1'b0);
    wait_done(vc);
    step();
    chk("inj_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    // Single-word frames.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("fl1_valid", 32'(valid1), 32'd1);
    chk("fl1_data0", data1, 32'd0);
    step();
    chk("fl1_done", 32'(done1), 32'd1);
    chk("fl1_valid_off", 32'(valid1), 32'd0);
    chk("fl1_cnt", 32'(cnt1), 32'd1);
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("fl1_data1", data1, 32'd1);
    step();
    chk("fl1_cnt2", 32'(cnt1), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
